// File: rtl/button_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | button_debounce: three independent active-low button debouncers           |
// | Outputs: level, press/release pulses and long-press flag per channel.     |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
module button_debounce #(
  parameter int STABLE_CYCLES = 50000,
  parameter int HOLD_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] button_i,
  output logic [2:0] button_o,
  output logic [2:0] pressed_o,
  output logic [2:0] released_o,
  output logic [2:0] held_o
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Inversion sits ahead of the synchronizer so a reset value of 0 means "released".
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= ~button_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_chan
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               button_q, button_d;
    logic               pressed_q, pressed_d;
    logic               released_q, released_d;
    logic               held_q, held_d;
    logic               s;

    assign s = sync2_q[ch];

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pressed_d  = 1'b0;
      released_d = 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (s) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!s) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = ST_PRESSED;
            cnt_d     = '0;
            pressed_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!s) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (s) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d    = ST_RELEASED;
            cnt_d      = '0;
            released_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      endcase

      button_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);

      // Hold time counts cycles the debounced level was already high; release wins.
      hold_d = hold_q;
      if (released_d) begin
        hold_d = '0;
      end else if (button_q && (hold_q != HOLD_MAX)) begin
        hold_d = hold_q + HOLD_W'(1);
      end
      held_d = !released_d && (hold_d == HOLD_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q    <= ST_RELEASED;
        cnt_q      <= '0;
        hold_q     <= '0;
        button_q   <= 1'b0;
        pressed_q  <= 1'b0;
        released_q <= 1'b0;
        held_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        hold_q     <= hold_d;
        button_q   <= button_d;
        pressed_q  <= pressed_d;
        released_q <= released_d;
        held_q     <= held_d;
      end
    end

    assign button_o[ch]   = button_q;
    assign pressed_o[ch]  = pressed_q;
    assign released_o[ch] = released_q;
    assign held_o[ch]     = held_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_button_debounce: directed + random bench with a run-length level model |
// | Rev 1.0                                                                   |
// +----------------------------------------------------------------------------+
module tb_button_debounce;

  localparam int STABLE = 4;
  localparam int HOLD   = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] button_i = 3'b111;
  logic [2:0] button_o, pressed_o, released_o, held_o;

  int checks = 0;
  int errors = 0;

  // Reference model: a level flips after STABLE consecutive disagreeing samples.
  logic [2:0] m_sync1 = 3'b000, m_sync2 = 3'b000;
  logic [2:0] m_level = 3'b000, m_press = 3'b000, m_rel = 3'b000, m_held = 3'b000;
  int         m_run[3];
  int         m_hold[3];
  logic [2:0] prev_pulse = 3'b000;

  button_debounce #(.STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .button_i  (button_i),
    .button_o  (button_o),
    .pressed_o (pressed_o),
    .released_o(released_o),
    .held_o    (held_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_sync1 = 3'b000; m_sync2 = 3'b000; m_level = 3'b000;
    m_press = 3'b000; m_rel = 3'b000; m_held = 3'b000;
    for (int c = 0; c < 3; c++) begin
      m_run[c] = 0;
      m_hold[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] s;
    if (reset) begin
      model_clear();
      return;
    end
    s = m_sync2;
    m_sync2 = m_sync1;
    m_sync1 = ~raw;
    m_press = 3'b000;
    m_rel   = 3'b000;
    for (int c = 0; c < 3; c++) begin
      if (m_level[c] && m_hold[c] < HOLD) m_hold[c]++;
      if (s[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == STABLE) begin
          m_run[c] = 0;
          m_level[c] = s[c];
          if (s[c]) m_press[c] = 1'b1;
          else      m_rel[c]   = 1'b1;
        end
      end else begin
        m_run[c] = 0;
      end
      if (m_rel[c]) m_hold[c] = 0;
      m_held[c] = (m_hold[c] == HOLD);
    end
  endtask

  task automatic compare_all();
    chk("button_o",   button_o,   m_level);
    chk("pressed_o",  pressed_o,  m_press);
    chk("released_o", released_o, m_rel);
    chk("held_o",     held_o,     m_held);
    chk("pulse_overlap", pressed_o & released_o, 3'b000);
    chk("pulse_consecutive", (pressed_o | released_o) & prev_pulse, 3'b000);
    prev_pulse = pressed_o | released_o;
  endtask

  task automatic step(input logic [2:0] raw);
    button_i = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    compare_all();
  endtask

  logic [2:0] raw_r;
  int         ch1_activity;
  int         ch2_presses;

  initial begin
    model_clear();
    // Reset state
    #1;
    chk("reset_button", button_o, 3'b000);
    chk("reset_pulses", pressed_o | released_o | held_o, 3'b000);
    step(3'b111);
    step(3'b111);
    reset = 1'b0;

    // Clean press on R: level and pulse on edge 6, long-press on edge 16
    for (int i = 1; i <= 18; i++) begin
      step(3'b110);
      if (i == 5)  chk("press_edge5_button", button_o, 3'b000);
      if (i == 6)  chk("press_edge6_button", button_o, 3'b001);
      if (i == 6)  chk("press_edge6_pulse", pressed_o, 3'b001);
      if (i == 15) chk("held_edge15", held_o, 3'b000);
      if (i == 16) chk("held_edge16", held_o, 3'b001);
    end

    // Glitch on G: 3 low samples then high
    ch1_activity = 0;
    for (int i = 0; i < 3; i++) begin
      step(3'b100);
      ch1_activity += int'(button_o[1] | pressed_o[1] | released_o[1]);
    end
    for (int i = 0; i < 8; i++) begin
      step(3'b110);
      ch1_activity += int'(button_o[1] | pressed_o[1] | released_o[1]);
    end
    chk("glitch_g_quiet", 3'(ch1_activity), 3'b000);

    // Release R after long press: pulse and held clear together
    for (int i = 1; i <= 7; i++) begin
      step(3'b111);
      if (i == 5) chk("release_edge5_held", held_o, 3'b001);
      if (i == 6) chk("release_edge6_pulse", released_o, 3'b001);
      if (i == 6) chk("release_edge6_held", held_o, 3'b000);
    end

    // Bounce on B, then settle low
    ch2_presses = 0;
    step(3'b011); ch2_presses += int'(pressed_o[2]);
    step(3'b111); ch2_presses += int'(pressed_o[2]);
    step(3'b011); ch2_presses += int'(pressed_o[2]);
    step(3'b111); ch2_presses += int'(pressed_o[2]);
    for (int i = 0; i < 10; i++) begin
      step(3'b011);
      ch2_presses += int'(pressed_o[2]);
    end
    chk("bounce_single_press", 3'(ch2_presses), 3'b001);
    for (int i = 0; i < 8; i++) step(3'b111);

    // Independence: all pressed together, then only G released
    for (int i = 1; i <= 8; i++) begin
      step(3'b000);
      if (i == 6) chk("all_press_pulse", pressed_o, 3'b111);
    end
    for (int i = 1; i <= 8; i++) begin
      step(3'b010);
      if (i == 6) chk("g_release_pulse", released_o, 3'b010);
    end
    for (int i = 0; i < 8; i++) step(3'b111);

    // Reset mid-hold on G and mid-debounce on R
    for (int i = 0; i < 18; i++) step(3'b101);
    for (int i = 0; i < 4; i++) step(3'b100);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_button", button_o, 3'b000);
    chk("async_reset_held", held_o, 3'b000);
    chk("async_reset_pulses", pressed_o | released_o, 3'b000);
    model_clear();
    prev_pulse = 3'b000;
    step(3'b100);
    step(3'b100);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(3'b100);
      if (i == 5) chk("post_reset_edge5", pressed_o, 3'b000);
      if (i == 6) chk("post_reset_edge6", pressed_o, 3'b011);
    end
    for (int i = 0; i < 8; i++) step(3'b111);

    // Random toggling: a mix of short glitches and long stable runs
    raw_r = 3'b111;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 5) == 0) raw_r[c] = ~raw_r[c];
      end
      if ((i % 200) > 150) raw_r = (i % 400) > 200 ? 3'b000 : 3'b111;
      step(raw_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 50000, number of consecutive synchronized samples that must disagree with the debounced level before that level changes; legal range 2..2^20.
REQ-002 Parameter HOLD_CYCLES, default 25000000, number of cycles the debounced level must remain pressed before the long-press flag asserts; legal range 1..2^28.
REQ-003 clk  input  1  single module clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 button_i  input  3  raw active-low buttons (bit 0 R, bit 1 G, bit 2 B); asynchronous to clk.
REQ-006 button_o  output  3  debounced active-high button levels; this is the clean source for the downstream LED logic.
REQ-007 pressed_o  output  3  one-cycle pulse per channel on each debounced 0->1 transition.
REQ-008 released_o  output  3  one-cycle pulse per channel on each debounced 1->0 transition.
REQ-009 held_o  output  3  per-channel long-press level.

Function
REQ-010 The block shall pass each button_i bit through a two-flop synchronizer and invert it; s[n] denotes the second flop's output.
REQ-011 Channels shall be fully independent, with one counter and one state machine per channel and no shared state.
REQ-012 Per-channel states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED: s=1 -> PRESS_WAIT with count=1; otherwise remain in RELEASED with count=0.
REQ-014 PRESS_WAIT: s=0 -> RELEASED with count=0 (glitch rejected, no pulse); s=1 and count=STABLE_CYCLES-1 -> PRESSED; otherwise count+1.
REQ-015 PRESSED: s=0 -> RELEASE_WAIT with count=1; otherwise remain in PRESSED.
REQ-016 RELEASE_WAIT: s=1 -> PRESSED with count=0 (glitch rejected); s=0 and count=STABLE_CYCLES-1 -> RELEASED; otherwise count+1.
REQ-017 button_o[n] shall be 1 exactly when channel n is in PRESSED or RELEASE_WAIT, and shall be registered.
REQ-018 pressed_o[n] shall be 1 for exactly the single cycle following the PRESS_WAIT->PRESSED edge; released_o[n] shall behave the same for RELEASE_WAIT->RELEASED.
REQ-019 Latency: for a clean raw edge first sampled on clock edge 1, button_o and the matching pulse shall change on edge STABLE_CYCLES+2.
REQ-020 pressed_o and released_o shall never assert together on the same channel, and shall never assert on consecutive cycles on the same channel.
REQ-021 A hold counter per channel shall increment each cycle button_o[n]=1, saturating at HOLD_CYCLES.
REQ-022 held_o[n] shall assert on the cycle the hold counter reaches HOLD_CYCLES.
REQ-023 The hold counter and held_o[n] shall clear in the same cycle that released_o[n] pulses.
REQ-024 held_o[n] shall stay asserted during RELEASE_WAIT.
REQ-025 Counter widths shall be derived as clog2(STABLE_CYCLES) and clog2(HOLD_CYCLES+1).
REQ-026 Counters shall never wrap.
REQ-027 Simultaneous edges on several channels shall produce simultaneous, independent pulses.

Reset
REQ-028 While reset=1: synchronizer flops=0, which treats buttons as released.
REQ-029 While reset=1: all states=RELEASED, all counters=0, and button_o, pressed_o, released_o, held_o=3'b000.
REQ-030 Reset asserted mid-debounce or mid-hold shall abort immediately, with no pulse emitted during or on exit from reset.
REQ-031 After reset deasserts with a button already held low, the press shall be reported normally after STABLE_CYCLES+2 edges.

Verification (STABLE_CYCLES=4, HOLD_CYCLES=10)
REQ-032 Clean press: button_i[0] 1->0 held, first sampled on edge 1 -> button_o=3'b001 and a single pressed_o=3'b001 pulse on edge 6; held_o[0]=1 on edge 16.
REQ-033 Glitch rejection: button_i[1] low for 3 samples, then high -> button_o, pressed_o and released_o stay 0 throughout.
REQ-034 Bounce then settle: button_i[2] toggling 0,1,0,1, then held 0 -> exactly one pressed_o[2] pulse, 4 cycles after the synchronized level last settles.
REQ-035 Release after long press: button_i[0] returned high -> released_o[0] pulses and held_o[0]=0 on the same edge, STABLE_CYCLES+2 edges after the first high sample.
REQ-036 Independence: all three buttons pressed on the same edge -> pressed_o=3'b111 for one cycle; then releasing only G gives released_o=3'b010.
REQ-037 Reset mid-operation: assert reset during PRESS_WAIT on channel 0 -> all outputs 0 asynchronously; if the button is still held, the press is reported 6 edges after deassertion, with no pulse during reset.
